uart_rx_line_capture: RTL and testbench

Receive-side counterpart of the UART TX line feeder. It consumes the byte stream from the UART RX module at 20 MHz and assembles printable ASCII characters into a 34-byte line in the same format the TX feeder consumes: 32 characters, left-justified and space-padded, followed by CR LF. A completed line, terminated by LF, is presented on a valid/ready handshake to the command/display logic.

---
 rtl/uart_line_pkg.sv | 27 ++
 rtl/uart_rx_line_capture.sv | 111 +++++++++++
 tb/tb_uart_rx_line_capture.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_line_pkg.sv
// Shared line geometry, ASCII constants and RX line-capture state type.
// Used by both the UART RX line capture and the UART TX line feeder.
package uart_line_pkg;

    localparam int c_line_bytes = 34;
    localparam int c_line_chars = 32;

    localparam logic [7:0] c_ascii_lf  = 8'h0A;
    localparam logic [7:0] c_ascii_cr  = 8'h0D;
    localparam logic [7:0] c_ascii_bs  = 8'h08;
    localparam logic [7:0] c_ascii_del = 8'h7F;
    localparam logic [7:0] c_ascii_sp  = 8'h20;

    localparam logic [8*c_line_bytes-1:0] c_line_of_spaces =
        {{c_line_chars{c_ascii_sp}}, c_ascii_cr, c_ascii_lf};

    typedef enum logic [1:0] {
        ST_RXLINE_FILL = 2'd0,
        ST_RXLINE_DISC = 2'd1,
        ST_RXLINE_HOLD = 2'd2
    } t_rxline_state;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= c_ascii_sp) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/uart_rx_line_capture.sv
// Assembles received printable bytes into a 34-byte space-padded CRLF line
// and holds it on a valid/ready handshake until the consumer takes it.
module uart_rx_line_capture
    import uart_line_pkg::*;
(
    input  logic         i_clk_20mhz,
    input  logic         i_rst_20mhz,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic [271:0] o_line_ascii,
    output logic         o_line_valid,
    input  logic         i_line_ready,
    output logic [5:0]   o_line_len,
    output logic         o_line_trunc,
    output logic         o_rx_drop
);

    t_rxline_state state_q, state_d;
    logic [271:0]  buf_q, buf_d;
    logic [5:0]    len_q, len_d;
    logic          trunc_q, trunc_d;
    logic          valid_q, valid_d;
    logic          drop_q, drop_d;

    // Bit offset of the next free slot and of the last stored slot.
    logic [8:0] wr_lsb;
    logic [8:0] bs_lsb;

    assign wr_lsb = 9'd264 - {len_q, 3'b000};
    assign bs_lsb = 9'd272 - {len_q, 3'b000};

    // Next-state: character classification, slot writes and handshake.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        case (state_q)
            ST_RXLINE_FILL: begin
                if (i_rx_valid) begin
                    if (i_rx_data == c_ascii_lf) begin
                        state_d = ST_RXLINE_HOLD;
                        valid_d = 1'b1;
                    end else if (i_rx_data == c_ascii_bs ||
                                 i_rx_data == c_ascii_del) begin
                        if (len_q != 6'd0) begin
                            len_d = len_q - 6'd1;
                            buf_d[bs_lsb +: 8] = c_ascii_sp;
                        end
                    end else if (is_printable(i_rx_data)) begin
                        buf_d[wr_lsb +: 8] = i_rx_data;
                        len_d = len_q + 6'd1;
                        if (len_q == 6'(c_line_chars - 1)) begin
                            state_d = ST_RXLINE_DISC;
                        end
                    end
                end
            end
            ST_RXLINE_DISC: begin
                // Line is full: everything but LF is thrown away.
                if (i_rx_valid && i_rx_data == c_ascii_lf) begin
                    trunc_d = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_RXLINE_HOLD;
                end
            end
            ST_RXLINE_HOLD: begin
                // No backpressure upstream, so bytes here are lost.
                drop_d = i_rx_valid;
                if (i_line_ready) begin
                    buf_d   = c_line_of_spaces;
                    len_d   = 6'd0;
                    trunc_d = 1'b0;
                    valid_d = 1'b0;
                    state_d = ST_RXLINE_FILL;
                end
            end
            default: begin
                state_d = ST_RXLINE_FILL;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state_q <= ST_RXLINE_FILL;
            buf_q   <= c_line_of_spaces;
            len_q   <= 6'd0;
            trunc_q <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign o_line_ascii = buf_q;
    assign o_line_valid = valid_q;
    assign o_line_len   = len_q;
    assign o_line_trunc = trunc_q;
    assign o_rx_drop    = drop_q;

endmodule

// File: tb/tb_uart_rx_line_capture.sv
// Directed bench for uart_rx_line_capture: fill, edit, truncation,
// hold/drop, handshake collision, back-to-back bytes and async reset.
module tb_uart_rx_line_capture;

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [271:0] line_ascii;
    logic         line_valid;
    logic         line_ready;
    logic [5:0]   line_len;
    logic         line_trunc;
    logic         rx_drop;

    int n_vec;
    int n_err;

    uart_rx_line_capture dut (
        .i_clk_20mhz  (clk),
        .i_rst_20mhz  (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_line_ascii (line_ascii),
        .o_line_valid (line_valid),
        .i_line_ready (line_ready),
        .o_line_len   (line_len),
        .o_line_trunc (line_trunc),
        .o_rx_drop    (rx_drop)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    // Expected line image: text left-justified, space padded, CR LF.
    function automatic logic [271:0] make_line(input string s);
        logic [271:0] l;
        l = {{32{8'h20}}, 8'h0D, 8'h0A};
        for (int i = 0; i < s.len() && i < 32; i++) begin
            l[271 - 8*i -: 8] = s[i];
        end
        return l;
    endfunction

    function automatic logic [271:0] make_rep(input logic [7:0] c,
                                              input int n);
        logic [271:0] l;
        l = {{32{8'h20}}, 8'h0D, 8'h0A};
        for (int i = 0; i < n && i < 32; i++) begin
            l[271 - 8*i -: 8] = c;
        end
        return l;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic accept();
        @(negedge clk);
        line_ready = 1'b1;
        @(negedge clk);
        line_ready = 1'b0;
    endtask

    task automatic check_line(input string name,
                              input logic [271:0] exp_line,
                              input logic [5:0] exp_len,
                              input logic exp_trunc);
        n_vec++;
        if ({line_valid, line_trunc, line_len, line_ascii} !==
            {1'b1, exp_trunc, exp_len, exp_line}) begin
            n_err++;
            $display("FAIL %s: got v=%b t=%b len=%0d line=%h expected v=1 t=%b len=%0d line=%h",
                     name, line_valid, line_trunc, line_len, line_ascii,
                     exp_trunc, exp_len, exp_line);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({line_valid, line_trunc, line_len, rx_drop} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_flags: got v=%b t=%b len=%0d drop=%b expected all 0",
                     line_valid, line_trunc, line_len, rx_drop);
        end
        n_vec++;
        if (line_ascii !== make_line("")) begin
            n_err++;
            $display("FAIL reset_line: got %h expected %h",
                     line_ascii, make_line(""));
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hello();
        send_str("HELLO");
        n_vec++;
        if (line_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hello_not_yet_valid: got %b expected 0", line_valid);
        end
        send_byte(8'h0A);
        check_line("hello", make_line("HELLO"), 6'd5, 1'b0);
        accept();
    endtask

    task automatic test_backspace();
        send_byte(8'h08);
        send_byte(8'h7F);
        send_str("AB");
        send_byte(8'h08);
        send_str("C");
        send_byte(8'h0D);
        send_byte(8'h01);
        send_byte(8'h0A);
        check_line("backspace", make_line("AC"), 6'd2, 1'b0);
        accept();
        send_str("XY");
        send_byte(8'h7F);
        send_byte(8'h0A);
        check_line("delete", make_line("X"), 6'd1, 1'b0);
        accept();
        send_byte(8'h0A);
        check_line("empty_lf", make_line(""), 6'd0, 1'b0);
        accept();
    endtask

    task automatic test_trunc();
        for (int i = 0; i < 40; i++) send_byte("x");
        send_byte(8'h0A);
        check_line("trunc40", make_rep("x", 32), 6'd32, 1'b1);
        accept();
        for (int i = 0; i < 32; i++) send_byte("y");
        n_vec++;
        if (line_valid !== 1'b0 || line_len !== 6'd32) begin
            n_err++;
            $display("FAIL full_no_valid: got v=%b len=%0d expected v=0 len=32",
                     line_valid, line_len);
        end
        send_byte(8'h08);
        send_byte(8'h0A);
        check_line("trunc32", make_rep("y", 32), 6'd32, 1'b1);
        accept();
    endtask

    task automatic test_hold_drop();
        send_str("Y");
        send_byte(8'h0A);
        send_byte("Z");
        n_vec++;
        if (rx_drop !== 1'b1) begin
            n_err++;
            $display("FAIL hold_drop_pulse: got %b expected 1", rx_drop);
        end
        @(negedge clk);
        n_vec++;
        if (rx_drop !== 1'b0) begin
            n_err++;
            $display("FAIL hold_drop_single: got %b expected 0", rx_drop);
        end
        check_line("hold_unchanged", make_line("Y"), 6'd1, 1'b0);
        accept();
        n_vec++;
        if ({line_valid, line_len, line_ascii} !== {1'b0, 6'd0, make_line("")}) begin
            n_err++;
            $display("FAIL after_accept: got v=%b len=%0d line=%h expected v=0 len=0 spaces",
                     line_valid, line_len, line_ascii);
        end
        send_str("Q");
        send_byte(8'h0A);
        check_line("after_hold_q", make_line("Q"), 6'd1, 1'b0);
        accept();
    endtask

    task automatic test_handshake_drop();
        send_str("M");
        send_byte(8'h0A);
        @(negedge clk);
        line_ready = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = "K";
        @(negedge clk);
        line_ready = 1'b0;
        rx_valid   = 1'b0;
        n_vec++;
        if ({rx_drop, line_valid, line_len} !== {1'b1, 1'b0, 6'd0}) begin
            n_err++;
            $display("FAIL handshake_drop: got drop=%b v=%b len=%0d expected drop=1 v=0 len=0",
                     rx_drop, line_valid, line_len);
        end
        send_str("N");
        send_byte(8'h0A);
        check_line("handshake_next", make_line("N"), 6'd1, 1'b0);
        accept();
    endtask

    task automatic test_back_to_back();
        string s;
        s = "abc";
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_data  = s[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_data = 8'h0A;
        @(negedge clk);
        rx_valid = 1'b0;
        check_line("back_to_back", make_line("abc"), 6'd3, 1'b0);
        accept();
    endtask

    task automatic test_async_reset();
        send_str("ABC");
        #5;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({line_valid, line_trunc, line_len, line_ascii} !==
            {1'b0, 1'b0, 6'd0, make_line("")}) begin
            n_err++;
            $display("FAIL async_reset: got v=%b t=%b len=%0d line=%h expected reset values",
                     line_valid, line_trunc, line_len, line_ascii);
        end
        @(negedge clk);
        rst = 1'b0;
        send_str("D");
        send_byte(8'h0A);
        check_line("after_reset", make_line("D"), 6'd1, 1'b0);
        accept();
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        line_ready = 1'b0;
        test_reset();
        test_hello();
        test_backspace();
        test_trunc();
        test_hold_drop();
        test_handshake_drop();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
